// File: rtl/iter_div_seq.sv
// iter_div_seq: iterative radix-2 restoring integer divider with RISC-V
// DIV/DIVU/REM/REMU semantics. It produces one quotient bit per clock.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   start      request pulse; accepted in IDLE or DONE
//   flush      aborts an in-flight operation (returns to IDLE)
//   signed_op  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   x, y       dividend and divisor, sampled with start
//   busy       iteration in progress
//   done       one-cycle result-valid pulse
//   quotient   quotient result (held until the next completion)
//   remainder  remainder result (held until the next completion)
module iter_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic            signed_op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [XLEN-1:0] prem_reg, prem_next;       // partial remainder
  logic [XLEN-1:0] dvd_reg, dvd_next;         // dividend, shifts into quotient
  logic [XLEN-1:0] dvs_reg, dvs_next;         // divisor magnitude
  logic            op_signed_reg, op_signed_next;
  logic            x_sign_reg, x_sign_next;
  logic            y_sign_reg, y_sign_next;
  logic [XLEN-1:0] quotient_reg, quotient_next;
  logic [XLEN-1:0] remainder_reg, remainder_next;

  // Operand magnitudes at accept time.
  logic            x_neg, y_neg;
  logic [XLEN-1:0] x_mag, y_mag;

  // One restoring step.
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            q_bit;
  logic [XLEN-1:0] prem_iter, dvd_iter;

  // Sign fixup for the result produced on the final iteration.
  logic            neg_q, neg_r;
  logic [XLEN-1:0] q_fix, r_fix;

  assign x_neg = signed_op & x[XLEN-1];
  assign y_neg = signed_op & y[XLEN-1];
  assign x_mag = x_neg ? (~x + 1'b1) : x;
  assign y_mag = y_neg ? (~y + 1'b1) : y;

  assign shifted = {prem_reg, dvd_reg[XLEN-1]};
  // Extra top bit of diff acts as the borrow: set means the trial went negative.
  assign diff      = {1'b0, shifted} - {2'b00, dvs_reg};
  assign q_bit     = ~diff[XLEN+1];
  // When the trial succeeds the difference is below the divisor, and when it
  // fails the shifted value is below the divisor, so XLEN bits always suffice.
  assign prem_iter = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign dvd_iter  = {dvd_reg[XLEN-2:0], q_bit};

  // The magnitude path turns -2^(XLEN-1) / -1 into 2^(XLEN-1) with equal
  // signs, so no negation is applied and the overflow result equals x.
  assign neg_q = op_signed_reg & (x_sign_reg ^ y_sign_reg);
  assign neg_r = op_signed_reg & x_sign_reg;
  assign q_fix = neg_q ? (~dvd_iter + 1'b1) : dvd_iter;
  assign r_fix = neg_r ? (~prem_iter + 1'b1) : prem_iter;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    prem_next      = prem_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    op_signed_next = op_signed_reg;
    x_sign_next    = x_sign_reg;
    y_sign_next    = y_sign_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;

    if (flush) begin
      // Abort wins over start; results from the previous operation are kept.
      state_next = IDLE;
    end else begin
      case (state_reg)
        BUSY: begin
          prem_next = prem_iter;
          dvd_next  = dvd_iter;
          if (cnt_reg == '0) begin
            state_next     = DONE;
            quotient_next  = q_fix;
            remainder_next = r_fix;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          state_next = IDLE;
          if (start) begin
            if (y == '0) begin
              // Divide by zero finishes immediately, sign-independent.
              state_next     = DONE;
              quotient_next  = '1;
              remainder_next = x;
            end else begin
              state_next     = BUSY;
              cnt_next       = CW'(XLEN - 1);
              prem_next      = '0;
              dvd_next       = x_mag;
              dvs_next       = y_mag;
              op_signed_next = signed_op;
              x_sign_next    = x[XLEN-1];
              y_sign_next    = y[XLEN-1];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      op_signed_reg <= 1'b0;
      x_sign_reg    <= 1'b0;
      y_sign_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prem_reg      <= prem_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      op_signed_reg <= op_signed_next;
      x_sign_reg    <= x_sign_next;
      y_sign_reg    <= y_sign_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  assign busy      = (state_reg == BUSY);
  assign done      = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: doc/iter_div_seq.md
Name: iter_div_seq

Overview:
- Iterative radix-2 restoring integer divider for the M-extension datapath.
- Sits directly upstream of the iteration registers. Its per-cycle load/enable decisions and next-state values are what enable/load flops capture.
- Accepts one divide request at a time, iterates one quotient bit per cycle, and presents quotient and remainder with a one-cycle done pulse.
- Follows RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width in bits; power of two, minimum 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled on rising clk edge
- flush  in  1  abort in-flight operation
- signed_op  in  1  1 = signed (DIV/REM), 0 = unsigned
- x  in  XLEN  dividend, sampled with start
- y  in  XLEN  divisor, sampled with start
- busy  out  1  iteration in progress
- done  out  1  one-cycle result-valid pulse
- quotient  out  XLEN  quotient result
- remainder  out  XLEN  remainder result

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset). Priority: reset > flush > start.
- Reset values: state IDLE, busy=0, done=0, quotient=0, remainder=0, iteration counter=0.
- State machine:
  - IDLE: start=1 accepts the request.
  - DONE: start=1 is also accepted (back-to-back operation).
  - BUSY: start is ignored; operands are not resampled.
- Accept, nonzero divisor:
  - At accept edge E0, latch |x|, |y| (absolute values only when signed_op=1), the sign of each operand, and signed_op.
  - Clear the partial remainder and load counter = XLEN-1. Go to BUSY.
- BUSY iteration, one per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement the counter. When the counter is 0 at an edge, that edge performs the final iteration and moves to DONE. The BUSY state therefore lasts exactly XLEN cycles (E1..EXLEN).
- Sign fixup, applied combinationally when entering DONE:
  - Quotient is negated when signed_op=1 and sign(x) != sign(y).
  - Remainder takes the sign of x when signed_op=1.
- DONE: done=1 and busy=0 for exactly one cycle. The next edge goes to IDLE, or back to BUSY if start=1.
- Timing: with start high in cycle 0, done is high in cycle XLEN+1.
- Result hold: quotient/remainder hold their values until the next accepted start. At that start they are not cleared; they update only on entry to DONE.
- Divide by zero (y=0): at E0 go directly to DONE with quotient = all ones and remainder = x, for both signed and unsigned. done is high in cycle 1.
- Signed overflow (x = -2^(XLEN-1), y = -1, signed): quotient = x, remainder = 0. This must fall out of the magnitude algorithm plus fixup; no special case is needed, but it must be verified.
- flush:
  - In BUSY or DONE: go to IDLE at the next edge, done=0, quotient/remainder unchanged from the prior result.
  - flush together with start in IDLE: start is dropped.
- reset mid-operation: IDLE on the next edge, outputs at reset values, no done pulse.
- busy = (state == BUSY), registered-state decode, no combinational path from start.

Test Plan:
- Unsigned, XLEN=32: start with x=100, y=7, signed_op=0 -> busy high cycles 1..32, done cycle 33, quotient=14, remainder=2.
- Signed: x=-7 (0xFFFFFFF9), y=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed x=7, y=-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: x=5, y=0, both signed_op values -> done in cycle 1, quotient=0xFFFFFFFF, remainder=5, busy never asserted.
- Signed overflow: x=0x80000000, y=0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0. Unsigned same operands -> quotient=0, remainder=0x80000000.
- Control:
  - start pulsed again in cycle 10 of an operation -> ignored, original result returned.
  - flush in cycle 10 -> busy=0 from cycle 11, no done, outputs hold the prior result.
  - Next start 100/7 completes normally.
- Reset asserted in cycle 5 of an operation -> IDLE, done/busy/quotient/remainder all 0 next cycle. Back-to-back start in the DONE cycle -> second result's done in cycle XLEN+1 after it.
